region_marker: RTL
==================

// Module: region_marker
// PURPOSE
//  Transmit side of the MSB-toggle region framing used on the 8-bit pixel stream. Buffers 7-bit
//  payload packets and serialises them one sample per HSYNC-qualified HCLK. Bit 7 is a level
//  marker: 1 inside a region, 0 outside, so a downstream toggle-detector gates exactly the payload.
//  Sits between the pixel source and the VGA data path, upstream of the region remover.
// PARAMETERS
//  FIFO_DEPTH    16  payload buffer entries (power of 2, >=4)
//  PREAMBLE_LEN  3   idle samples emitted after reset before any region may open
//  GAP_LEN       2   minimum idle samples between regions (used only with REGION_MARKER_GAP_EN)
// PORTS
//  HCLK       in   1  clock, all logic on posedge
//  HRESETn    in   1  synchronous active-low reset, sampled on posedge HCLK
//  HSYNC      in   1  sample strobe; stream advances only on cycles with HSYNC=1
//  in_valid   in   1  payload word valid
//  in_ready   out  1  FIFO can accept; transfer when in_valid&in_ready
//  in_data    in   7  payload word
//  in_last    in   1  marks final word of a packet
//  tx_data    out  8  framed stream {marker, payload}
//  underrun   out  1  one-cycle pulse: FIFO empty while inside a region
// BEHAVIOUR
//  Reset (HRESETn=0 at posedge): tx_data=8'h00, underrun=0, FIFO emptied, in_ready=0,
//   state=PREAMBLE, preamble count=0, packet count=0. Reset mid-region drops the region at once.
//  in_ready = !full && state!=PREAMBLE; accepts on any cycle, independent of HSYNC.
//  FIFO entry = {last, data}; pkt_cnt counts buffered entries with last=1 (+1 on write of last,
//   -1 on read of last; simultaneous both -> unchanged).
//  All state/output changes below occur only on posedge with HSYNC=1; HSYNC=0 holds everything.
//  PREAMBLE: tx_data=8'h00; after PREAMBLE_LEN samples -> IDLE.
//  IDLE: tx_data=8'h00. If pkt_cnt>0 or FIFO full: pop word, tx_data={1'b1,data} -> ACTIVE
//   (or stay IDLE-equivalent close if that word has last, see below).
//  ACTIVE: each sample pops next word, tx_data={1'b1,data}.
//   Popped word with last=1 is the final region sample; next sample tx_data=8'h00 (close) -> IDLE.
//   FIFO empty in ACTIVE: tx_data=8'h80 filler, underrun=1 for that cycle, stay ACTIVE.
//  Single-word packet: one sample 8'h8x, then 8'h00.
//  Latency: word written while IDLE with complete packet buffered appears on tx_data at the
//   second HSYNC posedge after write (one for FIFO, one registered output). tx_data is registered.
//  Back-to-back: without gap feature, a close sample (8'h00) is always emitted between packets.
//  Write to full FIFO impossible (in_ready=0); read+write same cycle when full is legal.
// CONFIGURATION
//  REGION_MARKER_GAP_EN defined: IDLE after a close waits GAP_LEN extra 8'h00 samples (state GAP,
//   counter) before opening the next region. Undefined: next region may open on the sample
//   directly after the close sample; no GAP state or counter synthesised.
// STRUCTURE
//  Shared package region_pkg: MARK_BIT=7, IDLE_WORD=8'h00, FILLER_WORD=8'h80, PAYLOAD_W=7,
//   state enum {PREAMBLE, IDLE, ACTIVE, GAP}.
//  Sub-module marker_fifo: synchronous FIFO, width PAYLOAD_W+1, depth FIFO_DEPTH, full/empty/count.
//  Top: FSM, preamble/gap counters, pkt_cnt, output register.
// TESTING
//  Reset, HSYNC=1 constant -> tx_data 00,00,00; in_ready rises after 3rd sample.
//  Push 0x11,0x22,0x33(last) -> tx_data 91,A2,B3,00; receiver model outputs 91,A2,B3 only.
//  Two 2-word packets back-to-back -> 81,82,00,83,84,00 (GAP_EN: two extra 00 before 83).
//  HSYNC toggled 1/0 during a region -> tx_data holds on HSYNC=0 cycles, sequence unchanged.
//  Fill 16 words no last -> in_ready=0, region opens on full; source stalls -> 80 filler, underrun=1.
//  Assert HRESETn=0 mid-region -> next cycle tx_data=00, FIFO empty, preamble restarts.

Source files
------------

// File: rtl/region_pkg.sv
// ---------------------------------------------------------------------------------------------
// region_pkg: shared constants for the MSB-toggle region framing on the 8-bit pixel stream.
//
// Contents
//   MARK_BIT     bit position of the region level marker in a framed sample
//   PAYLOAD_W    payload width carried below the marker
//   IDLE_WORD    sample emitted outside a region (preamble, close, gap)
//   FILLER_WORD  sample emitted inside a region when no payload is buffered
//   state_t      FSM state encoding (StPreamble, StIdle, StActive, StGap)
//   frame_word   builds an in-region sample from a payload word
// ---------------------------------------------------------------------------------------------
package region_pkg;

  localparam int unsigned MARK_BIT  = 7;
  localparam int unsigned PAYLOAD_W = 7;

  localparam logic [7:0] IDLE_WORD   = 8'h00;
  localparam logic [7:0] FILLER_WORD = 8'h80;

  // Plain constants keep the encoding visible to legacy tooling that dislikes enums.
  typedef logic [1:0] state_t;
  localparam state_t StPreamble = 2'd0;
  localparam state_t StIdle     = 2'd1;
  localparam state_t StActive   = 2'd2;
  localparam state_t StGap      = 2'd3;

  function automatic logic [7:0] frame_word(input logic [PAYLOAD_W-1:0] data);
    logic [7:0] w;
    w                  = '0;
    w[PAYLOAD_W-1:0]   = data;
    w[MARK_BIT]        = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/marker_fifo.sv
// ---------------------------------------------------------------------------------------------
// marker_fifo: synchronous FIFO holding {last, payload} entries for region_marker.
//
// Ports
//   clk_i      clock, posedge
//   rst_ni     synchronous active-low reset (empties the FIFO)
//   wr_en_i    write request; ignored when full unless a read happens in the same cycle
//   wr_data_i  entry to write
//   rd_en_i    read request; ignored when empty
//   rd_data_o  head entry (combinational, valid when !empty_o)
//   full_o     Depth entries buffered
//   empty_o    no entries buffered
//   count_o    number of buffered entries
// Depth must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------------------------
module marker_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [Width-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [AddrW:0]   cnt_q, cnt_d;
  logic             wr_ok, rd_ok;

  assign full_o    = (cnt_q == (AddrW+1)'(Depth));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign rd_data_o = mem_q[rptr_q];

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign wr_ok = wr_en_i && (!full_o || rd_en_i);
  assign rd_ok = rd_en_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/region_marker.sv
// ---------------------------------------------------------------------------------------------
// region_marker: transmit side of the MSB-toggle region framing on the 8-bit pixel stream.
// Buffers 7-bit payload packets and emits one framed sample per HSYNC-qualified HCLK edge.
// tx_data[7] is 1 inside a region and 0 outside, so a downstream toggle detector gates exactly
// the payload.
//
// Ports
//   HCLK      clock, all logic on posedge
//   HRESETn   synchronous active-low reset
//   HSYNC     sample strobe; the stream only advances on edges with HSYNC=1
//   in_valid  payload word valid
//   in_ready  FIFO can accept (not full, preamble finished); independent of HSYNC
//   in_data   7-bit payload word
//   in_last   final word of a packet
//   tx_data   registered framed sample {marker, payload}
//   underrun  one-cycle pulse when a region sample finds the FIFO empty (filler 8'h80 sent)
//
// Configuration
//   REGION_MARKER_GAP_EN  when defined, GAP_LEN extra idle samples follow every close sample
//                         before the next region may open; when undefined the GAP state and
//                         its counter are not built.
// ---------------------------------------------------------------------------------------------
module region_marker
  import region_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PREAMBLE_LEN = 3,
  parameter int unsigned GAP_LEN      = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSYNC,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 in_last,
  output logic [7:0]           tx_data,
  output logic                 underrun
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PreW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN + 1) : 1;

  // FIFO interface
  logic               wr_en;
  logic               pop;
  logic [PAYLOAD_W:0] rd_entry;
  logic               rd_last;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CntW-1:0]    fifo_count;

  // State
  state_t             state_q, state_d;
  logic [PreW-1:0]    pre_q, pre_d;
  logic [CntW-1:0]    pkt_q, pkt_d;
  logic               last_q, last_d;    // last popped word closed the packet
  logic [7:0]         tx_q, tx_d;
  logic               und_q, und_d;
  logic               open_ok;

`ifdef REGION_MARKER_GAP_EN
  localparam int unsigned GapW = (GAP_LEN > 1) ? $clog2(GAP_LEN + 1) : 1;
  logic [GapW-1:0]    gap_q, gap_d;
`else
  logic               unused_gap_len;
  assign unused_gap_len = ^GAP_LEN;
`endif

  marker_fifo #(
    .Width (PAYLOAD_W + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (HCLK),
    .rst_ni    (HRESETn),
    .wr_en_i   (wr_en),
    .wr_data_i ({in_last, in_data}),
    .rd_en_i   (pop),
    .rd_data_o (rd_entry),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign in_ready = !fifo_full && (state_q != StPreamble);
  assign wr_en    = in_valid && in_ready;
  assign rd_last  = rd_entry[PAYLOAD_W];

  // A region opens once a whole packet is buffered, or when the FIFO is full and waiting for
  // the rest of the packet would deadlock the source.
  assign open_ok  = (pkt_q != '0) || (fifo_count == CntW'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    last_d  = last_q;
    tx_d    = tx_q;
    und_d   = 1'b0;
    pop     = 1'b0;
`ifdef REGION_MARKER_GAP_EN
    gap_d   = gap_q;
`endif

    if (HSYNC) begin
      case (state_q)
        StPreamble: begin
          tx_d = IDLE_WORD;
          if (pre_q == PreW'(PREAMBLE_LEN - 1)) begin
            pre_d   = '0;
            state_d = StIdle;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end

        StIdle: begin
          tx_d = IDLE_WORD;
          if (open_ok) begin
            pop     = 1'b1;
            tx_d    = frame_word(rd_entry[PAYLOAD_W-1:0]);
            last_d  = rd_last;
            state_d = StActive;
          end
        end

        StActive: begin
          if (last_q) begin
            // Close sample: marker drops for at least one sample between packets.
            tx_d    = IDLE_WORD;
            last_d  = 1'b0;
`ifdef REGION_MARKER_GAP_EN
            gap_d   = '0;
            state_d = StGap;
`else
            state_d = StIdle;
`endif
          end else if (fifo_empty) begin
            tx_d  = FILLER_WORD;
            und_d = 1'b1;
          end else begin
            pop    = 1'b1;
            tx_d   = frame_word(rd_entry[PAYLOAD_W-1:0]);
            last_d = rd_last;
          end
        end

`ifdef REGION_MARKER_GAP_EN
        StGap: begin
          tx_d = IDLE_WORD;
          if (gap_q == GapW'(GAP_LEN - 1)) begin
            gap_d   = '0;
            state_d = StIdle;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
`endif

        default: begin
          tx_d    = IDLE_WORD;
          pre_d   = '0;
          last_d  = 1'b0;
          state_d = StPreamble;
        end
      endcase
    end
  end

  // Count of complete packets buffered; a simultaneous write and read of a last word cancel.
  always_comb begin
    pkt_d = pkt_q;
    if ((wr_en && in_last) && !(pop && rd_last)) begin
      pkt_d = pkt_q + 1'b1;
    end else if (!(wr_en && in_last) && (pop && rd_last)) begin
      pkt_d = pkt_q - 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= StPreamble;
      pre_q   <= '0;
      pkt_q   <= '0;
      last_q  <= 1'b0;
      tx_q    <= IDLE_WORD;
      und_q   <= 1'b0;
`ifdef REGION_MARKER_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      pkt_q   <= pkt_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      und_q   <= und_d;
`ifdef REGION_MARKER_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign tx_data  = tx_q;
  assign underrun = und_q;

endmodule
